// File: rtl/dma_controller_xfer.sv
// DMA transfer engine: takes one arbiter grant, moves one beat (read then write) over an
// Avalon-MM style master and hands the post-beat channel state back to the register file.
module dma_controller_xfer #(
  parameter int unsigned CHANNELS_AMOUNT = 4,
  parameter int unsigned CHANNEL_CNT_W   = $clog2(CHANNELS_AMOUNT),
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  input  logic                              req_valid_i,
  input  logic [CHANNEL_CNT_W-1:0]          req_num_i,
  output logic                              ready_o,

  input  logic [CHANNELS_AMOUNT*ADDR_W-1:0] ch_src_addr_i,
  input  logic [CHANNELS_AMOUNT*ADDR_W-1:0] ch_dst_addr_i,
  input  logic [CHANNELS_AMOUNT*CNT_W-1:0]  ch_cnt_i,
  input  logic [CHANNELS_AMOUNT-1:0]        ch_src_inc_i,
  input  logic [CHANNELS_AMOUNT-1:0]        ch_dst_inc_i,

  output logic [ADDR_W-1:0]                 mm_address_o,
  output logic                              mm_read_o,
  output logic                              mm_write_o,
  output logic [DATA_W-1:0]                 mm_writedata_o,
  input  logic [DATA_W-1:0]                 mm_readdata_i,
  input  logic                              mm_readdatavalid_i,
  input  logic                              mm_waitrequest_i,

  output logic                              upd_valid_o,
  output logic [CHANNEL_CNT_W-1:0]          upd_num_o,
  output logic [ADDR_W-1:0]                 upd_src_addr_o,
  output logic [ADDR_W-1:0]                 upd_dst_addr_o,
  output logic [CNT_W-1:0]                  upd_cnt_o,
  output logic [CHANNELS_AMOUNT-1:0]        tc_o
);

  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(DATA_W / 8);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRd,
    StRdw,
    StWr,
    StUpd
  } state_e;

  state_e                     state_q, state_d;

  // Grant snapshot, frozen for the whole beat
  logic [CHANNEL_CNT_W-1:0]   num_q, num_d;
  logic [ADDR_W-1:0]          src_q, src_d;
  logic [ADDR_W-1:0]          dst_q, dst_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       src_inc_q, src_inc_d;
  logic                       dst_inc_q, dst_inc_d;

  logic                       ready_q, ready_d;
  logic                       rd_q, rd_d;
  logic                       wr_q, wr_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;

  logic                       upd_valid_q, upd_valid_d;
  logic [CHANNEL_CNT_W-1:0]   upd_num_q, upd_num_d;
  logic [ADDR_W-1:0]          upd_src_q, upd_src_d;
  logic [ADDR_W-1:0]          upd_dst_q, upd_dst_d;
  logic [CNT_W-1:0]           upd_cnt_q, upd_cnt_d;
  logic [CHANNELS_AMOUNT-1:0] tc_q, tc_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      num_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      ready_q     <= 1'b1;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_num_q   <= '0;
      upd_src_q   <= '0;
      upd_dst_q   <= '0;
      upd_cnt_q   <= '0;
      tc_q        <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      src_inc_q   <= src_inc_d;
      dst_inc_q   <= dst_inc_d;
      ready_q     <= ready_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      upd_valid_q <= upd_valid_d;
      upd_num_q   <= upd_num_d;
      upd_src_q   <= upd_src_d;
      upd_dst_q   <= upd_dst_d;
      upd_cnt_q   <= upd_cnt_d;
      tc_q        <= tc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    src_inc_d   = src_inc_q;
    dst_inc_d   = dst_inc_q;
    ready_d     = ready_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    upd_valid_d = 1'b0;
    upd_num_d   = upd_num_q;
    upd_src_d   = upd_src_q;
    upd_dst_d   = upd_dst_q;
    upd_cnt_d   = upd_cnt_q;
    tc_d        = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          num_d     = req_num_i;
          src_d     = ch_src_addr_i[req_num_i * ADDR_W +: ADDR_W];
          dst_d     = ch_dst_addr_i[req_num_i * ADDR_W +: ADDR_W];
          cnt_d     = ch_cnt_i[req_num_i * CNT_W +: CNT_W];
          src_inc_d = ch_src_inc_i[req_num_i];
          dst_inc_d = ch_dst_inc_i[req_num_i];
          ready_d   = 1'b0;
          state_d   = StLoad;
        end
      end

      StLoad: begin
        if (cnt_q == '0) begin
          // Empty channel: report back untouched state, no bus traffic, no tc
          upd_valid_d = 1'b1;
          upd_num_d   = num_q;
          upd_src_d   = src_q;
          upd_dst_d   = dst_q;
          upd_cnt_d   = '0;
          state_d     = StUpd;
        end else begin
          rd_d    = 1'b1;
          addr_d  = src_q;
          state_d = StRd;
        end
      end

      StRd: begin
        if (!mm_waitrequest_i) begin
          rd_d = 1'b0;
          // Zero-latency slaves may return data in the accept cycle itself
          if (mm_readdatavalid_i) begin
            wr_d    = 1'b1;
            addr_d  = dst_q;
            wdata_d = mm_readdata_i;
            state_d = StWr;
          end else begin
            state_d = StRdw;
          end
        end
      end

      StRdw: begin
        if (mm_readdatavalid_i) begin
          wr_d    = 1'b1;
          addr_d  = dst_q;
          wdata_d = mm_readdata_i;
          state_d = StWr;
        end
      end

      StWr: begin
        if (!mm_waitrequest_i) begin
          wr_d        = 1'b0;
          upd_valid_d = 1'b1;
          upd_num_d   = num_q;
          upd_src_d   = src_q + (src_inc_q ? AddrStep : '0);
          upd_dst_d   = dst_q + (dst_inc_q ? AddrStep : '0);
          upd_cnt_d   = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            tc_d[num_q] = 1'b1;
          end
          state_d     = StUpd;
        end
      end

      StUpd: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ready_o        = ready_q;
  assign mm_address_o   = addr_q;
  assign mm_read_o      = rd_q;
  assign mm_write_o     = wr_q;
  assign mm_writedata_o = wdata_q;
  assign upd_valid_o    = upd_valid_q;
  assign upd_num_o      = upd_num_q;
  assign upd_src_addr_o = upd_src_q;
  assign upd_dst_addr_o = upd_dst_q;
  assign upd_cnt_o      = upd_cnt_q;
  assign tc_o           = tc_q;

endmodule

// File: tb/tb_dma_controller_xfer.sv
// Bench for dma_controller_xfer: random grants against a transaction-level model, a scripted
// Avalon slave, and a few directed scenarios with hand-computed expectations.
module tb_dma_controller_xfer;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid = 1'b0;
  logic [1:0]    req_num = '0;
  logic          ready_o;
  logic [127:0]  ch_src_addr = '0;
  logic [127:0]  ch_dst_addr = '0;
  logic [63:0]   ch_cnt = '0;
  logic [3:0]    ch_src_inc = '0;
  logic [3:0]    ch_dst_inc = '0;
  logic [31:0]   mm_address_o;
  logic          mm_read_o;
  logic          mm_write_o;
  logic [31:0]   mm_writedata_o;
  logic [31:0]   mm_readdata = '0;
  logic          mm_readdatavalid = 1'b0;
  logic          mm_waitrequest = 1'b0;
  logic          upd_valid_o;
  logic [1:0]    upd_num_o;
  logic [31:0]   upd_src_addr_o;
  logic [31:0]   upd_dst_addr_o;
  logic [15:0]   upd_cnt_o;
  logic [3:0]    tc_o;

  always #5 clk_i = ~clk_i;

  dma_controller_xfer dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid),
    .req_num_i          (req_num),
    .ready_o            (ready_o),
    .ch_src_addr_i      (ch_src_addr),
    .ch_dst_addr_i      (ch_dst_addr),
    .ch_cnt_i           (ch_cnt),
    .ch_src_inc_i       (ch_src_inc),
    .ch_dst_inc_i       (ch_dst_inc),
    .mm_address_o       (mm_address_o),
    .mm_read_o          (mm_read_o),
    .mm_write_o         (mm_write_o),
    .mm_writedata_o     (mm_writedata_o),
    .mm_readdata_i      (mm_readdata),
    .mm_readdatavalid_i (mm_readdatavalid),
    .mm_waitrequest_i   (mm_waitrequest),
    .upd_valid_o        (upd_valid_o),
    .upd_num_o          (upd_num_o),
    .upd_src_addr_o     (upd_src_addr_o),
    .upd_dst_addr_o     (upd_dst_addr_o),
    .upd_cnt_o          (upd_cnt_o),
    .tc_o               (tc_o)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Slave behaviour knobs
  int          cfg_rd_wait = 0;
  int          cfg_wr_wait = 0;
  int          cfg_rdv_delay = 1;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = '0;
  logic [31:0] s_rdata = '0;
  int          s_rd_acc = 0;
  int          s_wr_acc = 0;

  // Transaction-level model state
  bit          in_flight = 1'b0;
  int          n_accepts = 0;
  logic [1:0]  m_num;
  logic [31:0] m_src, m_dst;
  logic [15:0] m_cnt;
  bit          m_sinc, m_dinc;
  int          m_reads = 0;
  int          m_writes = 0;

  task automatic deliver();
    mm_readdatavalid = 1'b1;
    mm_readdata      = force_data_en ? force_data : $urandom;
    s_rdata          = mm_readdata;
  endtask

  // Memory slave: stalls each new strobe for a configured count, returns read data later
  initial begin : slave
    int wait_left, rdv_cnt;
    bit prev_strobe, prev_wait;
    wait_left = 0; rdv_cnt = 0; prev_strobe = 0; prev_wait = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        mm_waitrequest = 1'b0; mm_readdatavalid = 1'b0;
        rdv_cnt = 0; prev_strobe = 0; prev_wait = 0;
        continue;
      end
      mm_readdatavalid = 1'b0;
      mm_readdata      = $urandom;
      if (rdv_cnt > 0) begin
        rdv_cnt--;
        if (rdv_cnt == 0) deliver();
      end
      if (mm_read_o || mm_write_o) begin
        if (!(prev_strobe && prev_wait)) wait_left = mm_read_o ? cfg_rd_wait : cfg_wr_wait;
        if (wait_left > 0) begin
          mm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          mm_waitrequest = 1'b0;
          if (mm_read_o) begin
            s_rd_acc++;
            if (cfg_rdv_delay == 0) deliver();
            else rdv_cnt = cfg_rdv_delay;
          end else begin
            s_wr_acc++;
          end
        end
      end else begin
        mm_waitrequest = 1'($urandom_range(0, 1));
      end
      prev_strobe = mm_read_o || mm_write_o;
      prev_wait   = mm_waitrequest;
    end
  end

  // Model: snapshot the grant at acceptance, count bus acceptances, retire on update
  initial begin : model
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        in_flight = 1'b0;
        continue;
      end
      if (upd_valid_o) in_flight = 1'b0;
      if (mm_read_o && !mm_waitrequest) m_reads++;
      if (mm_write_o && !mm_waitrequest) m_writes++;
      if (req_valid && ready_o) begin
        m_num     = req_num;
        m_src     = ch_src_addr[req_num*32 +: 32];
        m_dst     = ch_dst_addr[req_num*32 +: 32];
        m_cnt     = ch_cnt[req_num*16 +: 16];
        m_sinc    = ch_src_inc[req_num];
        m_dinc    = ch_dst_inc[req_num];
        m_reads   = 0;
        m_writes  = 0;
        in_flight = 1'b1;
        n_accepts++;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin : compare
    bit prev_rd_stall, prev_wr_stall;
    logic [31:0] e_src, e_dst;
    logic [15:0] e_cnt;
    logic [3:0]  e_tc;
    int          e_beats;
    prev_rd_stall = 0; prev_wr_stall = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_rd_stall = 0; prev_wr_stall = 0;
        continue;
      end
      check("ready", ready_o, !in_flight);
      check("rd_wr_exclusive", mm_read_o & mm_write_o, 0);
      if (prev_rd_stall) check("rd_held", mm_read_o, 1);
      if (prev_wr_stall) check("wr_held", mm_write_o, 1);
      if (mm_read_o) begin
        check("rd_busy", in_flight, 1);
        check("rd_nonzero_cnt", m_cnt != 0, 1);
        check("rd_single", m_reads, 0);
        check("rd_addr", mm_address_o, m_src);
      end
      if (mm_write_o) begin
        check("wr_after_rd", m_reads, 1);
        check("wr_single", m_writes, 0);
        check("wr_addr", mm_address_o, m_dst);
        check("wr_data", mm_writedata_o, s_rdata);
      end
      if (upd_valid_o) begin
        e_beats = (m_cnt != 0) ? 1 : 0;
        e_src   = m_src + ((m_sinc && e_beats == 1) ? 32'd4 : 32'd0);
        e_dst   = m_dst + ((m_dinc && e_beats == 1) ? 32'd4 : 32'd0);
        e_cnt   = (e_beats == 1) ? m_cnt - 16'd1 : 16'd0;
        e_tc    = (m_cnt == 16'd1) ? (4'b0001 << m_num) : 4'b0000;
        check("upd_busy", in_flight, 1);
        check("upd_num", upd_num_o, m_num);
        check("upd_src", upd_src_addr_o, e_src);
        check("upd_dst", upd_dst_addr_o, e_dst);
        check("upd_cnt", upd_cnt_o, e_cnt);
        check("upd_tc", tc_o, e_tc);
        check("upd_reads", m_reads, e_beats);
        check("upd_writes", m_writes, e_beats);
      end else begin
        check("tc_idle", tc_o, 0);
      end
      prev_rd_stall = mm_read_o && mm_waitrequest;
      prev_wr_stall = mm_write_o && mm_waitrequest;
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'hFFFF_FFF8;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  function automatic logic [15:0] pick_cnt();
    case ($urandom_range(0, 3))
      0:       return 16'd0;
      1:       return 16'd1;
      2:       return 16'd2;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic scramble_cfg();
    for (int n = 0; n < 4; n++) begin
      ch_src_addr[n*32 +: 32] = pick_addr();
      ch_dst_addr[n*32 +: 32] = pick_addr();
      ch_cnt[n*16 +: 16]      = pick_cnt();
    end
    ch_src_inc = 4'($urandom);
    ch_dst_inc = 4'($urandom);
  endtask

  task automatic set_ch(input int n, input logic [31:0] src, input logic [31:0] dst,
                        input logic [15:0] cnt, input bit sinc, input bit dinc);
    ch_src_addr[n*32 +: 32] = src;
    ch_dst_addr[n*32 +: 32] = dst;
    ch_cnt[n*16 +: 16]      = cnt;
    ch_src_inc[n]           = sinc;
    ch_dst_inc[n]           = dinc;
  endtask

  // Raise a grant and run until the update pulse is visible; lat = cycles from accept to update
  task automatic grant(input int ch, input bit hold, input bit scramble, output int lat);
    int  acc0, k_acc;
    bit  acc, done;
    acc0 = n_accepts; acc = 0; done = 0; lat = -1; k_acc = 0;
    req_num   = 2'(ch);
    req_valid = 1'b1;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(posedge clk_i); #1;
      if (!acc && n_accepts != acc0) begin
        acc = 1; k_acc = k;
        if (!hold) req_valid = 1'b0;
      end
      if (scramble && acc) scramble_cfg();
      if (upd_valid_o) begin
        lat = k - k_acc; done = 1; req_valid = 1'b0;
      end
    end
    if (!done) begin
      req_valid = 1'b0;
      expire("grant_timeout");
    end
  endtask

  initial begin : main
    int lat, rd0, wr0;
    bit seen_rd, in_rdw;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_read", mm_read_o, 0);
    check("rst_write", mm_write_o, 0);
    check("rst_upd_valid", upd_valid_o, 0);
    check("rst_tc", tc_o, 0);
    check("rst_addr", mm_address_o, 0);
    check("rst_upd_cnt", upd_cnt_o, 0);
    rst_i = 1'b0;

    // Channel 2, zero wait, cycle-accurate minimum latency
    set_ch(2, 32'h1000, 32'h2000, 16'd5, 1'b1, 1'b1);
    cfg_rd_wait = 0; cfg_wr_wait = 0; cfg_rdv_delay = 1;
    force_data_en = 1'b1; force_data = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    req_num = 2'd2; req_valid = 1'b1;
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    scramble_cfg();
    check("c2_ready_drop", ready_o, 0);
    @(posedge clk_i); #1;
    check("c2_read_t1", mm_read_o, 1);
    check("c2_raddr_t1", mm_address_o, 32'h1000);
    @(posedge clk_i); #1;
    check("c2_read_t2", mm_read_o, 0);
    check("c2_write_t2", mm_write_o, 0);
    @(posedge clk_i); #1;
    check("c2_write_t3", mm_write_o, 1);
    check("c2_waddr_t3", mm_address_o, 32'h2000);
    check("c2_wdata_t3", mm_writedata_o, 32'hDEAD_BEEF);
    @(posedge clk_i); #1;
    check("c2_upd_t4", upd_valid_o, 1);
    check("c2_num", upd_num_o, 2);
    check("c2_src", upd_src_addr_o, 32'h1004);
    check("c2_dst", upd_dst_addr_o, 32'h2004);
    check("c2_cnt", upd_cnt_o, 4);
    check("c2_tc", tc_o, 0);
    @(posedge clk_i); #1;
    check("c2_ready_t5", ready_o, 1);
    check("c2_upd_t5", upd_valid_o, 0);
    force_data_en = 1'b0;

    // Channel 1, last beat with destination wrap
    set_ch(1, 32'h3000, 32'hFFFF_FFFC, 16'd1, 1'b0, 1'b1);
    grant(1, 1'b0, 1'b0, lat);
    check("c1_lat", lat, 4);
    check("c1_src", upd_src_addr_o, 32'h3000);
    check("c1_dst", upd_dst_addr_o, 32'h0000_0000);
    check("c1_cnt", upd_cnt_o, 0);
    check("c1_tc", tc_o, 4'b0010);
    @(posedge clk_i); #1;
    check("c1_tc_pulse", tc_o, 0);

    // Channel 0, zero count: no bus traffic
    set_ch(0, 32'h5000, 32'h6000, 16'd0, 1'b1, 1'b1);
    rd0 = s_rd_acc; wr0 = s_wr_acc;
    grant(0, 1'b0, 1'b0, lat);
    check("c0_lat", lat, 1);
    check("c0_src", upd_src_addr_o, 32'h5000);
    check("c0_dst", upd_dst_addr_o, 32'h6000);
    check("c0_cnt", upd_cnt_o, 0);
    check("c0_tc", tc_o, 0);
    check("c0_no_rd", s_rd_acc - rd0, 0);
    check("c0_no_wr", s_wr_acc - wr0, 0);

    // Stalls on both phases, delayed read data, request held high throughout
    set_ch(3, 32'h7000, 32'h8000, 16'd9, 1'b1, 1'b0);
    cfg_rd_wait = 3; cfg_wr_wait = 2; cfg_rdv_delay = 4;
    rd0 = s_rd_acc; wr0 = s_wr_acc;
    grant(3, 1'b1, 1'b0, lat);
    check("stall_lat", lat, 12);
    check("stall_one_rd", s_rd_acc - rd0, 1);
    check("stall_one_wr", s_wr_acc - wr0, 1);
    check("stall_src", upd_src_addr_o, 32'h7004);
    check("stall_dst", upd_dst_addr_o, 32'h8000);
    check("stall_cnt", upd_cnt_o, 8);

    // Reset while waiting for read data
    set_ch(3, 32'h4000, 32'h9000, 16'd7, 1'b1, 1'b1);
    cfg_rd_wait = 0; cfg_wr_wait = 0; cfg_rdv_delay = 4;
    req_num = 2'd3; req_valid = 1'b1;
    seen_rd = 0; in_rdw = 0;
    for (int k = 0; k < 20 && !in_rdw; k++) begin
      @(posedge clk_i); #1;
      if (mm_read_o) begin
        seen_rd = 1; req_valid = 1'b0;
      end else if (seen_rd) begin
        in_rdw = 1;
      end
    end
    if (!in_rdw) expire("rst_reach_rdw");
    #2 rst_i = 1'b1;
    #1;
    check("arst_ready", ready_o, 1);
    check("arst_read", mm_read_o, 0);
    check("arst_write", mm_write_o, 0);
    check("arst_upd", upd_valid_o, 0);
    check("arst_tc", tc_o, 0);
    check("arst_addr", mm_address_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      check("post_rst_no_upd", upd_valid_o, 0);
    end
    cfg_rdv_delay = 1;
    grant(3, 1'b0, 1'b0, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_src", upd_src_addr_o, 32'h4004);
    check("post_rst_cnt", upd_cnt_o, 6);

    // Random grants; model checks every cycle
    for (int t = 0; t < 150; t++) begin
      scramble_cfg();
      cfg_rd_wait   = $urandom_range(0, 3);
      cfg_wr_wait   = $urandom_range(0, 3);
      cfg_rdv_delay = $urandom_range(0, 4);
      grant($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (4) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dma_controller_xfer.md
Name: dma_controller_xfer

Overview:
Transfer engine on the consumer side of the DMA channel arbiter's req_valid/req_num/ready handshake. It accepts one granted channel number, runs a single-beat read-then-write over an Avalon-MM style memory master using that channel's configuration, and returns updated address/count values to the channel register file. It also flags transfer-complete per channel. One arbitration grant equals exactly one data beat.

Parameters:
CHANNELS_AMOUNT, 4, number of DMA channels
CHANNEL_CNT_W, $clog2(CHANNELS_AMOUNT), channel index width
ADDR_W, 32, byte address width
DATA_W, 32, data beat width; address step = DATA_W/8
CNT_W, 16, remaining-beat counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_valid_i  in  1  arbiter has a granted channel
req_num_i  in  CHANNEL_CNT_W  granted channel index
ready_o  out  1  engine can accept a grant
ch_src_addr_i  in  CHANNELS_AMOUNT*ADDR_W  per-channel current source address, packed; channel n at [n*ADDR_W +: ADDR_W]
ch_dst_addr_i  in  CHANNELS_AMOUNT*ADDR_W  per-channel current destination address, packed
ch_cnt_i  in  CHANNELS_AMOUNT*CNT_W  per-channel remaining beats
ch_src_inc_i  in  CHANNELS_AMOUNT  1 = increment source after the beat
ch_dst_inc_i  in  CHANNELS_AMOUNT  1 = increment destination after the beat
mm_address_o  out  ADDR_W  master address
mm_read_o  out  1  read strobe
mm_write_o  out  1  write strobe
mm_writedata_o  out  DATA_W  write data
mm_readdata_i  in  DATA_W  read data
mm_readdatavalid_i  in  1  read data valid
mm_waitrequest_i  in  1  slave stall
upd_valid_o  out  1  one-cycle pulse: write back channel state
upd_num_o  out  CHANNEL_CNT_W  channel being updated
upd_src_addr_o  out  ADDR_W  new source address
upd_dst_addr_o  out  ADDR_W  new destination address
upd_cnt_o  out  CNT_W  new remaining count
tc_o  out  CHANNELS_AMOUNT  one-cycle transfer-complete pulse, one-hot

Behaviour:
- Reset values (async, rst_i high): state IDLE_S; ready_o 1; mm_read_o, mm_write_o, upd_valid_o 0; tc_o 0. mm_address_o, mm_writedata_o, upd_* data are 0.
- Handshake: a grant is accepted on a cycle where req_valid_i && ready_o. ready_o = (state == IDLE_S), registered. ready_o drops the cycle after acceptance.
- States:
  - IDLE_S: on accept, latch channel index, src, dst, cnt and inc flags from the packed buses → LOAD_S.
  - LOAD_S: if latched cnt == 0 → UPD_S with no bus activity (zero-count grant). Otherwise drive mm_read_o=1 and mm_address_o=src → RD_S.
  - RD_S: hold mm_read_o/mm_address_o while mm_waitrequest_i=1. When mm_waitrequest_i=0, deassert mm_read_o next cycle → RDW_S.
  - RDW_S: on mm_readdatavalid_i, capture mm_readdata_i; drive mm_write_o=1, mm_address_o=dst, mm_writedata_o=data → WR_S. readdatavalid arriving in the same cycle the read is accepted is also legal; WR_S is then entered directly.
  - WR_S: hold write while mm_waitrequest_i=1. When mm_waitrequest_i=0, deassert next cycle → UPD_S.
  - UPD_S: pulse upd_valid_o for 1 cycle → IDLE_S.
- Update arithmetic:
  - upd_src_addr_o = src + (src_inc ? DATA_W/8 : 0), modulo 2^ADDR_W (wrap, no error).
  - Same rule for dst.
  - upd_cnt_o = cnt − 1.
  - For a zero-count grant: addresses are returned unchanged, cnt stays 0, and tc_o is not pulsed.
- tc_o[n] pulses in the UPD_S cycle when upd_cnt_o == 0 after a real beat (cnt was 1).
- Never more than one outstanding read. mm_read_o and mm_write_o are never high together.
- Minimum latency, zero waitrequest and readdatavalid one cycle after the read is accepted: accept(T) → read at T+1, write at T+3, upd_valid_o at T+4, ready_o high at T+5.
- req_valid_i while busy is ignored. The arbiter holds it; no queuing.
- Config buses are sampled only at accept. Later changes do not affect an in-flight beat.
- Reset mid-operation aborts the beat immediately: strobes drop asynchronously and no update or tc is issued.

Test Plan:
- Reset → ready_o=1, mm_read_o=mm_write_o=upd_valid_o=0, tc_o=0.
- Grant ch2: src=0x1000, dst=0x2000, cnt=5, both inc, zero wait, readdata 0xDEADBEEF → read @0x1000, write 0xDEADBEEF @0x2000; upd_num_o=2, src=0x1004, dst=0x2004, cnt=4; tc_o=0; upd_valid_o 4 cycles after accept.
- Grant ch1: cnt=1, src_inc=0, dst_inc=1, dst=0xFFFFFFFC → upd_src unchanged, upd_dst=0x00000000, upd_cnt=0, tc_o=4'b0010 for one cycle.
- Grant ch0 with cnt=0 → no mm_read_o/mm_write_o; upd_valid_o with unchanged values; tc_o stays 0.
- waitrequest held 3 cycles on read and 2 on write, readdatavalid delayed 4 cycles → address and strobes stable while stalled, exactly one read and one write; req_valid_i held high throughout is not accepted until ready_o returns.
- Assert rst_i during RDW_S → outputs return to reset values at once; no upd_valid_o or tc_o; next grant after reset completes normally.
